// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch path: the PC and instruction widths and the
// fetch controller state encoding.
package fetch_ctrl_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_VALID  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    // Sequential successor of a PC; wraps at the top of the address space.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
        return a + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch controller: drives the external PC register and presents one registered
// instruction per cycle to decode, with branch redirect, halt and stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int OFFSET_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     pc_next,
    output logic                pc_write,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_W-1:0]     instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                branch_req,
    input  logic                branch_rel,
    input  logic [PC_W-1:0]     branch_target,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic                halt_in,
    output logic                done
);

    fetch_state_t         r_state;
    fetch_state_t         w_state_nxt;
    logic [INSTR_W-1:0]   r_instr;
    logic [PC_W-1:0]      r_instr_pc;
    logic                 r_instr_valid;
    logic                 r_done;

    logic                 w_hs;
    logic                 w_load;
    logic                 w_valid_nxt;
    logic                 w_done_nxt;
    logic                 w_pc_write;
    logic [PC_W-1:0]      w_pc_next;
    logic [PC_W-1:0]      w_off_sext;
    logic [PC_W-1:0]      w_rel_target;

    // Relative branches are taken from the accepted instruction's own address.
    assign w_off_sext   = PC_W'(signed'(branch_offset));
    assign w_rel_target = r_instr_pc + w_off_sext;
    assign w_hs         = (r_state == ST_VALID) && r_instr_valid && instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_write  = 1'b0;
        w_pc_next   = pc_inc(pc);
        w_load      = 1'b0;
        w_valid_nxt = r_instr_valid;
        w_done_nxt  = r_done;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                if (start) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                w_pc_write  = 1'b1;
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (w_hs) begin
                    if (halt_in) begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_HALTED;
                    end else if (branch_req) begin
                        // Redirect: drop the prefetched slot and refill from the target.
                        w_pc_write  = 1'b1;
                        w_pc_next   = branch_rel ? w_rel_target : branch_target;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_FILL;
                    end else begin
                        w_pc_write = 1'b1;
                        w_load     = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr_valid <= w_valid_nxt;
            r_done        <= w_done_nxt;
            if (w_load) begin
                r_instr    <= imem_data;
                r_instr_pc <= pc;
            end
        end
    end

    // The PC register must not load while reset is held.
    assign pc_write    = w_pc_write & ~reset;
    assign pc_next     = w_pc_next;
    assign imem_addr   = pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign done        = r_done;

endmodule
